// File: rtl/jtag_tap_pkg.sv
// jtag_tap_pkg: TAP state codes and the 1149.1 next-state function
// shared by the JTAG monitor and its scan capture paths.
package jtag_tap_pkg;

  typedef logic [3:0] tap_state_t;

  localparam tap_state_t TAP_TLR    = 4'hF;
  localparam tap_state_t TAP_RTI    = 4'hC;
  localparam tap_state_t TAP_SEL_DR = 4'h7;
  localparam tap_state_t TAP_CAP_DR = 4'h6;
  localparam tap_state_t TAP_SH_DR  = 4'h2;
  localparam tap_state_t TAP_EX1_DR = 4'h1;
  localparam tap_state_t TAP_PA_DR  = 4'h3;
  localparam tap_state_t TAP_EX2_DR = 4'h0;
  localparam tap_state_t TAP_UPD_DR = 4'h5;
  localparam tap_state_t TAP_SEL_IR = 4'h4;
  localparam tap_state_t TAP_CAP_IR = 4'hE;
  localparam tap_state_t TAP_SH_IR  = 4'hA;
  localparam tap_state_t TAP_EX1_IR = 4'h9;
  localparam tap_state_t TAP_PA_IR  = 4'hB;
  localparam tap_state_t TAP_EX2_IR = 4'h8;
  localparam tap_state_t TAP_UPD_IR = 4'hD;

  function automatic tap_state_t tap_next(
    input tap_state_t s,
    input logic       tms
  );
    tap_state_t n;
    n = TAP_TLR;
    case (s)
      TAP_TLR:    n = tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    n = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: n = tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: n = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  n = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: n = tms ? TAP_UPD_DR : TAP_PA_DR;
      TAP_PA_DR:  n = tms ? TAP_EX2_DR : TAP_PA_DR;
      TAP_EX2_DR: n = tms ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: n = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: n = tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: n = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  n = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: n = tms ? TAP_UPD_IR : TAP_PA_IR;
      TAP_PA_IR:  n = tms ? TAP_EX2_IR : TAP_PA_IR;
      TAP_EX2_IR: n = tms ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR: n = tms ? TAP_SEL_DR : TAP_RTI;
      default:    n = TAP_TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_monitor_if.sv
// jtag_tap_monitor_if: raw JTAG pins and freeze into the monitor,
// decoded TAP state, windows and scans back out to the display path.
interface jtag_tap_monitor_if #(
  parameter int C_capture_bits = 64,
  parameter int C_len_bits     = 16
);

  logic                      tck;
  logic                      tms;
  logic                      tdi;
  logic                      tdo;
  logic                      freeze;
  logic [3:0]                tap_state;
  logic [C_capture_bits-1:0] tms_win;
  logic [C_capture_bits-1:0] tdi_win;
  logic [C_capture_bits-1:0] tdo_win;
  logic [C_capture_bits-1:0] ir_tdi;
  logic [C_capture_bits-1:0] ir_tdo;
  logic [C_capture_bits-1:0] dr_tdi;
  logic [C_capture_bits-1:0] dr_tdo;
  logic [C_len_bits-1:0]     ir_len;
  logic [C_len_bits-1:0]     dr_len;
  logic                      update_ir;
  logic                      update_dr;
  logic                      tck_edge;

  modport master (
    output tck, tms, tdi, tdo, freeze,
    input  tap_state, tms_win, tdi_win, tdo_win,
    input  ir_tdi, ir_tdo, dr_tdi, dr_tdo,
    input  ir_len, dr_len,
    input  update_ir, update_dr, tck_edge
  );

  modport slave (
    input  tck, tms, tdi, tdo, freeze,
    output tap_state, tms_win, tdi_win, tdo_win,
    output ir_tdi, ir_tdo, dr_tdi, dr_tdo,
    output ir_len, dr_len,
    output update_ir, update_dr, tck_edge
  );

endinterface

// File: rtl/jtag_scan_capture.sv
// jtag_scan_capture: one IR or DR scan path; shifters, bit counter,
// right-align and the freeze-gated result latch.
module jtag_scan_capture #(
  parameter int C_capture_bits = 64,
  parameter int C_len_bits     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      freeze,
  input  logic                      cap,
  input  logic                      shift,
  input  logic                      upd,
  input  logic                      tdi,
  input  logic                      tdo,
  output logic [C_capture_bits-1:0] scan_tdi,
  output logic [C_capture_bits-1:0] scan_tdo,
  output logic [C_len_bits-1:0]     scan_len,
  output logic                      upd_pulse
);

  localparam int N = C_capture_bits;

  logic [N-1:0]          sh_tdi;
  logic [N-1:0]          sh_tdo;
  logic [C_len_bits-1:0] cnt;
  int                    kept;
  int                    shamt;

  // Scans shorter than N sit in the top bits; slide them down to bit 0.
  always_comb begin
    kept  = (int'(cnt) >= N) ? N : int'(cnt);
    shamt = N - kept;
  end

  // Shifters, saturating counter and result latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_tdi    <= '0;
      sh_tdo    <= '0;
      cnt       <= '0;
      scan_tdi  <= '0;
      scan_tdo  <= '0;
      scan_len  <= '0;
      upd_pulse <= 1'b0;
    end else begin
      upd_pulse <= upd;
      if (cap) begin
        sh_tdi <= '0;
        sh_tdo <= '0;
        cnt    <= '0;
      end else if (shift) begin
        sh_tdi <= {tdi, sh_tdi[N-1:1]};
        sh_tdo <= {tdo, sh_tdo[N-1:1]};
        if (cnt != '1) cnt <= cnt + 1'b1;
      end
      if (upd && !freeze) begin
        scan_tdi <= sh_tdi >> shamt;
        scan_tdo <= sh_tdo >> shamt;
        scan_len <= cnt;
      end
    end
  end

endmodule

// File: rtl/jtag_tap_monitor.sv
// jtag_tap_monitor: passive TAP observer; synchronises the pins,
// tracks the TAP FSM, keeps raw windows and latches IR/DR scans.
module jtag_tap_monitor
  import jtag_tap_pkg::*;
#(
  parameter int C_capture_bits = 64,
  parameter int C_len_bits     = 16,
  parameter int C_sync_stages  = 2,
  parameter bit C_tck_invert   = 1'b0
) (
  input logic               clk,
  input logic               reset,
  jtag_tap_monitor_if.slave bus
);

  localparam int NS = C_sync_stages;
  localparam int N  = C_capture_bits;

  logic [NS-1:0]         sy_tck;
  logic [NS-1:0]         sy_tms;
  logic [NS-1:0]         sy_tdi;
  logic [NS-1:0]         sy_tdo;
  logic                  tck_s;
  logic                  tck_q;
  logic                  tms_d;
  logic                  tdi_d;
  logic                  tdo_d;
  logic                  smp;
  tap_state_t            state;
  tap_state_t            state_nx;
  logic                  cap_ir;
  logic                  cap_dr;
  logic                  sh_ir;
  logic                  sh_dr;
  logic                  up_ir;
  logic                  up_dr;
  logic                  edge_q;
  logic [N-1:0]          tms_win;
  logic [N-1:0]          tdi_win;
  logic [N-1:0]          tdo_win;
  logic [N-1:0]          ir_tdi;
  logic [N-1:0]          ir_tdo;
  logic [N-1:0]          dr_tdi;
  logic [N-1:0]          dr_tdo;
  logic [C_len_bits-1:0] ir_len;
  logic [C_len_bits-1:0] dr_len;
  logic                  ir_pulse;
  logic                  dr_pulse;

  assign tck_s = sy_tck[NS-1];
  assign smp   = C_tck_invert ? (tck_q & ~tck_s)
                              : (tck_s & ~tck_q);

  // Pin synchronisers; data gets one extra stage to line up with tck_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      sy_tck <= '0;
      sy_tms <= '0;
      sy_tdi <= '0;
      sy_tdo <= '0;
      tck_q  <= 1'b0;
      tms_d  <= 1'b0;
      tdi_d  <= 1'b0;
      tdo_d  <= 1'b0;
    end else begin
      sy_tck <= {sy_tck[NS-2:0], bus.tck};
      sy_tms <= {sy_tms[NS-2:0], bus.tms};
      sy_tdi <= {sy_tdi[NS-2:0], bus.tdi};
      sy_tdo <= {sy_tdo[NS-2:0], bus.tdo};
      tck_q  <= tck_s;
      tms_d  <= sy_tms[NS-1];
      tdi_d  <= sy_tdi[NS-1];
      tdo_d  <= sy_tdo[NS-1];
    end
  end

  // TAP state register.
  always_ff @(posedge clk) begin
    if (reset) state <= TAP_TLR;
    else       state <= state_nx;
  end

  // Next state and per-edge scan strobes from the pre-edge state.
  always_comb begin
    state_nx = state;
    cap_ir   = 1'b0;
    cap_dr   = 1'b0;
    sh_ir    = 1'b0;
    sh_dr    = 1'b0;
    up_ir    = 1'b0;
    up_dr    = 1'b0;
    if (smp) begin
      state_nx = tap_next(state, tms_d);
      sh_ir    = state == TAP_SH_IR;
      sh_dr    = state == TAP_SH_DR;
      cap_ir   = state_nx == TAP_CAP_IR;
      cap_dr   = state_nx == TAP_CAP_DR;
      up_ir    = state_nx == TAP_UPD_IR;
      up_dr    = state_nx == TAP_UPD_DR;
    end
  end

  // Raw sample windows, newest bit at bit 0, held while frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      tms_win <= '0;
      tdi_win <= '0;
      tdo_win <= '0;
      edge_q  <= 1'b0;
    end else begin
      edge_q <= smp;
      if (smp && !bus.freeze) begin
        tms_win <= {tms_win[N-2:0], tms_d};
        tdi_win <= {tdi_win[N-2:0], tdi_d};
        tdo_win <= {tdo_win[N-2:0], tdo_d};
      end
    end
  end

  jtag_scan_capture #(
    .C_capture_bits (C_capture_bits),
    .C_len_bits     (C_len_bits)
  ) u_ir (
    .clk       (clk),
    .reset     (reset),
    .freeze    (bus.freeze),
    .cap       (cap_ir),
    .shift     (sh_ir),
    .upd       (up_ir),
    .tdi       (tdi_d),
    .tdo       (tdo_d),
    .scan_tdi  (ir_tdi),
    .scan_tdo  (ir_tdo),
    .scan_len  (ir_len),
    .upd_pulse (ir_pulse)
  );

  jtag_scan_capture #(
    .C_capture_bits (C_capture_bits),
    .C_len_bits     (C_len_bits)
  ) u_dr (
    .clk       (clk),
    .reset     (reset),
    .freeze    (bus.freeze),
    .cap       (cap_dr),
    .shift     (sh_dr),
    .upd       (up_dr),
    .tdi       (tdi_d),
    .tdo       (tdo_d),
    .scan_tdi  (dr_tdi),
    .scan_tdo  (dr_tdo),
    .scan_len  (dr_len),
    .upd_pulse (dr_pulse)
  );

  assign bus.tap_state = state;
  assign bus.tms_win   = tms_win;
  assign bus.tdi_win   = tdi_win;
  assign bus.tdo_win   = tdo_win;
  assign bus.ir_tdi    = ir_tdi;
  assign bus.ir_tdo    = ir_tdo;
  assign bus.dr_tdi    = dr_tdi;
  assign bus.dr_tdo    = dr_tdo;
  assign bus.ir_len    = ir_len;
  assign bus.dr_len    = dr_len;
  assign bus.update_ir = ir_pulse;
  assign bus.update_dr = dr_pulse;
  assign bus.tck_edge  = edge_q;

endmodule

// File: tb/tb_jtag_tap_monitor.sv
// tb_jtag_tap_monitor: drives one JTAG stream into a rising-edge and a
// falling-edge monitor and checks both against a bit-queue model.
module tb_jtag_tap_monitor;

  localparam int N = 64;
  localparam int L = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tck = 1'b0;
  logic tms = 1'b0;
  logic tdi = 1'b0;
  logic tdo = 1'b0;
  logic freeze = 1'b0;
  bit   settled = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtag_tap_monitor_if #(.C_capture_bits(N), .C_len_bits(L)) b1 ();
  jtag_tap_monitor_if #(.C_capture_bits(N), .C_len_bits(L)) b2 ();

  assign b1.tck    = tck;
  assign b1.tms    = tms;
  assign b1.tdi    = tdi;
  assign b1.tdo    = tdo;
  assign b1.freeze = freeze;
  assign b2.tck    = ~tck;
  assign b2.tms    = tms;
  assign b2.tdi    = tdi;
  assign b2.tdo    = tdo;
  assign b2.freeze = freeze;

  jtag_tap_monitor #(
    .C_capture_bits (N),
    .C_len_bits     (L),
    .C_sync_stages  (2),
    .C_tck_invert   (1'b0)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  jtag_tap_monitor #(
    .C_capture_bits (N),
    .C_len_bits     (L),
    .C_sync_stages  (3),
    .C_tck_invert   (1'b1)
  ) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (b2)
  );

  // Model: TAP transition tables indexed by state code.
  logic [3:0] nx0 [16];
  logic [3:0] nx1 [16];
  logic [3:0] st;
  logic [N-1:0] mw_tms, mw_tdi, mw_tdo;
  logic [N-1:0] m_ir_tdi, m_ir_tdo, m_dr_tdi, m_dr_tdo;
  int m_ir_len, m_dr_len;
  bit q_ir_i[$], q_ir_o[$], q_dr_i[$], q_dr_o[$];
  int e_uir = 0, e_udr = 0, e_edg = 0;
  int n_uir [2] = '{0, 0};
  int n_udr [2] = '{0, 0};
  int n_edg [2] = '{0, 0};

  function automatic logic [N-1:0] pack(input bit q[$]);
    logic [N-1:0] v;
    int k;
    int s0;
    v = '0;
    k = (q.size() < N) ? q.size() : N;
    s0 = q.size() - k;
    for (int j = 0; j < k; j++) v[j] = q[s0 + j];
    return v;
  endfunction

  function automatic int sat(input int n);
    return (n > 65535) ? 65535 : n;
  endfunction

  task automatic model_reset();
    st = 4'hF;
    mw_tms = '0; mw_tdi = '0; mw_tdo = '0;
    m_ir_tdi = '0; m_ir_tdo = '0;
    m_dr_tdi = '0; m_dr_tdo = '0;
    m_ir_len = 0; m_dr_len = 0;
    q_ir_i.delete(); q_ir_o.delete();
    q_dr_i.delete(); q_dr_o.delete();
  endtask

  task automatic model_edge(input logic m, input logic di, input logic dq);
    logic [3:0] ns;
    ns = m ? nx1[st] : nx0[st];
    e_edg++;
    if (!freeze) begin
      mw_tms = {mw_tms[N-2:0], m};
      mw_tdi = {mw_tdi[N-2:0], di};
      mw_tdo = {mw_tdo[N-2:0], dq};
    end
    if (st == 4'hA) begin q_ir_i.push_back(di); q_ir_o.push_back(dq); end
    if (st == 4'h2) begin q_dr_i.push_back(di); q_dr_o.push_back(dq); end
    if (ns == 4'hE) begin q_ir_i.delete(); q_ir_o.delete(); end
    if (ns == 4'h6) begin q_dr_i.delete(); q_dr_o.delete(); end
    if (ns == 4'hD) begin
      e_uir++;
      if (!freeze) begin
        m_ir_tdi = pack(q_ir_i);
        m_ir_tdo = pack(q_ir_o);
        m_ir_len = sat(q_ir_i.size());
      end
    end
    if (ns == 4'h5) begin
      e_udr++;
      if (!freeze) begin
        m_dr_tdi = pack(q_dr_i);
        m_dr_tdo = pack(q_dr_o);
        m_dr_len = sat(q_dr_i.size());
      end
    end
    st = ns;
  endtask

  task automatic cmp(input string nm, input int d,
                     input logic [255:0] a, input logic [255:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h want %0h", nm, d, a, e);
    end
  endtask

  task automatic cmp_set(
    input int d, input logic [3:0] ts,
    input logic [N-1:0] wt, input logic [N-1:0] wi, input logic [N-1:0] wo,
    input logic [N-1:0] it, input logic [N-1:0] io,
    input logic [N-1:0] dt, input logic [N-1:0] dq,
    input logic [L-1:0] il, input logic [L-1:0] dl
  );
    cmp("tap_state", d, 256'(ts), 256'(st));
    cmp("tms_win", d, 256'(wt), 256'(mw_tms));
    cmp("tdi_win", d, 256'(wi), 256'(mw_tdi));
    cmp("tdo_win", d, 256'(wo), 256'(mw_tdo));
    cmp("ir_tdi", d, 256'(it), 256'(m_ir_tdi));
    cmp("ir_tdo", d, 256'(io), 256'(m_ir_tdo));
    cmp("dr_tdi", d, 256'(dt), 256'(m_dr_tdi));
    cmp("dr_tdo", d, 256'(dq), 256'(m_dr_tdo));
    cmp("ir_len", d, 256'(il), 256'(m_ir_len));
    cmp("dr_len", d, 256'(dl), 256'(m_dr_len));
    cmp("update_ir count", d, 256'(n_uir[d-1]), 256'(e_uir));
    cmp("update_dr count", d, 256'(n_udr[d-1]), 256'(e_udr));
    cmp("tck_edge count", d, 256'(n_edg[d-1]), 256'(e_edg));
  endtask

  // Pulse counters; a pulse wider than one clk counts twice.
  always @(posedge clk) begin
    if (b1.update_ir === 1'b1) n_uir[0]++;
    if (b1.update_dr === 1'b1) n_udr[0]++;
    if (b1.tck_edge === 1'b1) n_edg[0]++;
    if (b2.update_ir === 1'b1) n_uir[1]++;
    if (b2.update_dr === 1'b1) n_udr[1]++;
    if (b2.tck_edge === 1'b1) n_edg[1]++;
  end

  // Compare both monitors against the model whenever outputs are settled.
  always @(negedge clk) begin
    if (settled) begin
      cmp_set(1, b1.tap_state, b1.tms_win, b1.tdi_win, b1.tdo_win,
              b1.ir_tdi, b1.ir_tdo, b1.dr_tdi, b1.dr_tdo,
              b1.ir_len, b1.dr_len);
      cmp_set(2, b2.tap_state, b2.tms_win, b2.tdi_win, b2.tdo_win,
              b2.ir_tdi, b2.ir_tdo, b2.dr_tdi, b2.dr_tdo,
              b2.ir_len, b2.dr_len);
    end
  end

  task automatic step(input logic m, input logic di, input logic dq);
    @(posedge clk); #1;
    tms = m; tdi = di; tdo = dq;
    repeat (2) @(posedge clk);
    #1;
    settled = 1'b0;
    tck = 1'b1;
    model_edge(m, di, dq);
    repeat (5) @(posedge clk);
    #1;
    settled = 1'b1;
    tck = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic tms_seq(input logic [31:0] seq, input int n);
    for (int i = 0; i < n; i++) step(seq[i], 1'b0, 1'b0);
  endtask

  task automatic shift_n(input int n, input logic [255:0] di,
                         input logic [255:0] dq, input int off,
                         input bit exit_last);
    for (int i = 0; i < n; i++)
      step(exit_last && (i == n - 1), di[off + i], dq[off + i]);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    settled = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    settled = 1'b1;
  endtask

  task automatic lit(input string nm, input logic [255:0] a1,
                     input logic [255:0] a2, input logic [255:0] e);
    cmp(nm, 1, a1, e);
    cmp(nm, 2, a2, e);
  endtask

  logic [255:0] par;

  initial begin
    nx0 = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
            4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    nx1 = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
            4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};
    model_reset();
    do_reset();
    lit("reset tap_state", 256'(b1.tap_state), 256'(b2.tap_state), 256'(4'hF));
    lit("reset dr_len", 256'(b1.dr_len), 256'(b2.dr_len), 256'(0));

    // TLR return from SHIFT_DR with five tms=1 edges
    tms_seq(32'b0010, 4);
    lit("in SH_DR", 256'(b1.tap_state), 256'(b2.tap_state), 256'(4'h2));
    tms_seq(32'b11111, 5);
    lit("tlr return", 256'(b1.tap_state), 256'(b2.tap_state), 256'(4'hF));

    // 8-bit IR scan
    tms_seq(32'b00110, 5);
    shift_n(8, 256'(8'hE0), 256'(8'h01), 0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    lit("ir_tdi", 256'(b1.ir_tdi), 256'(b2.ir_tdi), 256'(8'hE0));
    lit("ir_tdo", 256'(b1.ir_tdo), 256'(b2.ir_tdo), 256'(8'h01));
    lit("ir_len", 256'(b1.ir_len), 256'(b2.ir_len), 256'(8));
    lit("upd_ir state", 256'(b1.tap_state), 256'(b2.tap_state), 256'(4'hD));
    lit("update_ir pulses", 256'(n_uir[0]), 256'(n_uir[1]), 256'(1));

    // 32-bit DR scan split by a pause
    tms_seq(32'b001, 3);
    shift_n(20, 256'(0), 256'(32'h41111043), 0, 1'b1);
    tms_seq(32'b0100, 4);
    shift_n(12, 256'(0), 256'(32'h41111043), 20, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    lit("dr_tdo pause", 256'(b1.dr_tdo), 256'(b2.dr_tdo), 256'(32'h41111043));
    lit("dr_len pause", 256'(b1.dr_len), 256'(b2.dr_len), 256'(32));

    // 70-bit DR scan overflowing the 64-bit register
    par = '0;
    for (int i = 0; i < 70; i++) par[i] = i[0];
    tms_seq(32'b001, 3);
    shift_n(70, par, 256'(0), 0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    lit("dr_len ovf", 256'(b1.dr_len), 256'(b2.dr_len), 256'(70));
    lit("dr_tdi ovf", 256'(b1.dr_tdi), 256'(b2.dr_tdi),
        256'(64'hAAAA_AAAA_AAAA_AAAA));

    // IR update while frozen: pulse but no output change
    tms_seq(32'b0011, 4);
    freeze = 1'b1;
    shift_n(8, 256'(8'h5A), 256'(8'hC3), 0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    lit("frozen ir_tdi", 256'(b1.ir_tdi), 256'(b2.ir_tdi), 256'(8'hE0));
    lit("frozen ir_len", 256'(b1.ir_len), 256'(b2.ir_len), 256'(8));
    lit("frozen pulses", 256'(n_uir[0]), 256'(n_uir[1]), 256'(2));
    freeze = 1'b0;

    // Reset in the middle of a DR shift, then a fresh short scan
    tms_seq(32'b001, 3);
    shift_n(5, 256'(5'h1F), 256'(0), 0, 1'b0);
    do_reset();
    lit("mid reset state", 256'(b1.tap_state), 256'(b2.tap_state), 256'(4'hF));
    lit("mid reset dr_len", 256'(b1.dr_len), 256'(b2.dr_len), 256'(0));
    tms_seq(32'b0010, 4);
    shift_n(4, 256'(4'h9), 256'(4'h6), 0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    lit("post reset dr_len", 256'(b1.dr_len), 256'(b2.dr_len), 256'(4));
    lit("post reset dr_tdi", 256'(b1.dr_tdi), 256'(b2.dr_tdi), 256'(4'h9));

    repeat (4) @(posedge clk);
    settled = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
